// File: rtl/inmux_pkg.sv
// Shared sizing and state encoding for the inmux skid stage and its helpers.
package inmux_pkg;

    localparam int SLICES     = 16;
    localparam int DATA_WIDTH = 16;
    localparam int SELW       = 4;
    localparam int CNTW       = 16;
    localparam int W          = SLICES * DATA_WIDTH;

    typedef logic [1:0] state_t;

    localparam state_t EMPTY = 2'd0;
    localparam state_t ONE   = 2'd1;
    localparam state_t FULL  = 2'd2;

endpackage

// File: rtl/inmux_sat_cnt.sv
// Event counter with synchronous clear; sat=1 holds at all-ones, sat=0 wraps.
module inmux_sat_cnt #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            clear,
    input  logic            inc,
    input  logic            sat,
    output logic [CNTW-1:0] cnt
);

    logic [CNTW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && !(sat && (&cnt_q))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/inmux_skid.sv
// Two-entry elastic stage behind the inmux data mux: registered data and ack,
// full throughput, plus debug counters for delivered beats and stalled cycles.
module inmux_skid
    import inmux_pkg::state_t, inmux_pkg::EMPTY, inmux_pkg::ONE, inmux_pkg::FULL;
#(
    parameter int SLICES     = inmux_pkg::SLICES,
    parameter int DATA_WIDTH = inmux_pkg::DATA_WIDTH,
    parameter int SELW       = inmux_pkg::SELW,
    parameter int CNTW       = inmux_pkg::CNTW,
    localparam int W         = SLICES * DATA_WIDTH
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [W-1:0]    t_inmux_dat,
    input  logic [SELW-1:0] t_inmux_sel,
    input  logic            t_inmux_req,
    output logic            t_inmux_ack,
    output logic [W-1:0]    i_dat,
    output logic [SELW-1:0] i_sel,
    output logic            i_req,
    input  logic            i_ack,
    output logic [CNTW-1:0] beat_cnt,
    output logic [CNTW-1:0] stall_cnt
);

    state_t          state_q, state_d;
    logic [W-1:0]    main_dat_q, main_dat_d;
    logic [W-1:0]    skid_dat_q, skid_dat_d;
    logic [SELW-1:0] main_sel_q, main_sel_d;
    logic [SELW-1:0] skid_sel_q, skid_sel_d;
    logic            ack_q, ack_d;

    logic in_beat;
    logic out_beat;
    logic stall;

    // ack_q is low in FULL, so an input beat can never arrive there.
    assign in_beat  = t_inmux_req & ack_q;
    assign out_beat = (state_q != EMPTY) & i_ack;
    assign stall    = (state_q != EMPTY) & ~i_ack;

    always_comb begin
        state_d    = state_q;
        main_dat_d = main_dat_q;
        main_sel_d = main_sel_q;
        skid_dat_d = skid_dat_q;
        skid_sel_d = skid_sel_q;
        case (state_q)
            EMPTY: begin
                if (in_beat) begin
                    main_dat_d = t_inmux_dat;
                    main_sel_d = t_inmux_sel;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (in_beat && out_beat) begin
                    main_dat_d = t_inmux_dat;
                    main_sel_d = t_inmux_sel;
                end else if (in_beat) begin
                    skid_dat_d = t_inmux_dat;
                    skid_sel_d = t_inmux_sel;
                    state_d    = FULL;
                end else if (out_beat) begin
                    state_d    = EMPTY;
                end
            end
            FULL: begin
                if (out_beat) begin
                    main_dat_d = skid_dat_q;
                    main_sel_d = skid_sel_q;
                    skid_dat_d = '0;
                    skid_sel_d = '0;
                    state_d    = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        ack_d = (state_d != FULL);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EMPTY;
            main_dat_q <= '0;
            main_sel_q <= '0;
            skid_dat_q <= '0;
            skid_sel_q <= '0;
            ack_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            main_dat_q <= main_dat_d;
            main_sel_q <= main_sel_d;
            skid_dat_q <= skid_dat_d;
            skid_sel_q <= skid_sel_d;
            ack_q      <= ack_d;
        end
    end

    assign t_inmux_ack = ack_q;
    assign i_dat       = main_dat_q;
    assign i_sel       = main_sel_q;
    assign i_req       = (state_q != EMPTY);

    inmux_sat_cnt #(.CNTW(CNTW)) u_beat_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (out_beat),
        .sat   (1'b0),
        .cnt   (beat_cnt)
    );

    inmux_sat_cnt #(.CNTW(CNTW)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (stall),
        .sat   (1'b1),
        .cnt   (stall_cnt)
    );

endmodule
